// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Package     : core_pkg
// Description : Shared definitions for the 5-stage RV32I core front end.
//               Provides the bubble instruction, the default reset PC and
//               the fetch FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

  // addi x0, x0, 0 : the canonical RV32I no-op used for pipeline bubbles
  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;

  // S_IDLE    : nothing outstanding, buffer empty
  // S_WAIT    : one live request outstanding
  // S_FULL    : buffer holds the word belonging to pc_f
  // S_DISCARD : one stale request outstanding (its word will be dropped)
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_FULL    = 2'd2,
    S_DISCARD = 2'd3
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_buffer
// Description : One-entry holding register for an instruction word and the
//               pc it belongs to. Used when a memory response arrives but
//               decode cannot take it this cycle.
// Ports       : clk, rst_n         - clock, async active-low reset
//               load               - capture word_in/pc_in, mark valid
//               clear              - drop the held entry (wins over load)
//               word_in, pc_in     - entry to capture
//               word, pc, valid    - held entry
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_buffer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            clear,
  input  logic [31:0]     word_in,
  input  logic [XLEN-1:0] pc_in,
  output logic [31:0]     word,
  output logic [XLEN-1:0] pc,
  output logic            valid
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      word  <= '0;
      pc    <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      word  <= word_in;
      pc    <= pc_in;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : IF stage plus IF/ID pipeline register. Owns pc_f, keeps at
//               most one instruction-memory request outstanding, buffers one
//               returned word and loads IF/ID under hazard-unit control.
// Ports       : clk, rst_n                 - clock, async active-low reset
//               stall_f, stall_d, flush_d  - hazard unit controls
//               pc_src_e, pc_target_e      - redirect resolved in EX
//               imem_req, imem_addr        - request pulse and address
//               imem_rvalid, imem_rdata    - response strobe and word
//               instr_d, pc_d, pc_plus4_d  - IF/ID contents
//               valid_d                    - IF/ID holds a real instruction
//               fetch_wait                 - bubble caused by missing word
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
  import core_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [31:0]     NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_f,
  input  logic            stall_d,
  input  logic            flush_d,
  input  logic            pc_src_e,
  input  logic [XLEN-1:0] pc_target_e,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instr_d,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pc_plus4_d,
  output logic            valid_d,
  output logic            fetch_wait
);

  fetch_state_t    state, state_next;
  logic [XLEN-1:0] pc_f, pc_next, pc_f_plus4;
  logic            avail, accept, issue;
  logic            buf_load, buf_clear, buf_valid;
  logic [31:0]     buf_word, word_f;
  logic [XLEN-1:0] buf_pc, word_pc;

  assign pc_f_plus4 = pc_f + XLEN'(4);

  // A word for pc_f exists either in the buffer or on the response bus.
  assign avail  = (state == S_FULL) | ((state == S_WAIT) & imem_rvalid);
  // stall_f is folded in so a held pc never lets IF/ID take the same word
  // twice; with stall_f alone the word is parked and IF/ID fills bubbles.
  assign accept = avail & ~stall_f & ~stall_d & ~flush_d & ~pc_src_e;

  assign word_f  = buf_valid ? buf_word : imem_rdata;
  assign word_pc = buf_valid ? buf_pc   : pc_f;

  fetch_buffer #(
    .XLEN (XLEN)
  ) u_fetch_buffer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (buf_load),
    .clear   (buf_clear),
    .word_in (imem_rdata),
    .pc_in   (pc_f),
    .word    (buf_word),
    .pc      (buf_pc),
    .valid   (buf_valid)
  );

  // Redirect overrides stall_f; advancing needs the word to be consumed.
  always_comb begin
    pc_next = pc_f;
    if (pc_src_e) begin
      pc_next = pc_target_e;
    end else if (accept) begin
      pc_next = pc_f_plus4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_f  <= RESET_PC;
      state <= S_IDLE;
    end else begin
      pc_f  <= pc_next;
      state <= state_next;
    end
  end

  // Every issue targets the next pc_f value, so the address is simply pc_next.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    buf_load   = 1'b0;
    buf_clear  = 1'b0;
    case (state)
      S_IDLE: begin
        issue      = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (pc_src_e || accept) begin
            issue = 1'b1;
          end else begin
            buf_load   = 1'b1;
            state_next = S_FULL;
          end
        end else if (pc_src_e) begin
          state_next = S_DISCARD;
        end
      end
      S_FULL: begin
        if (pc_src_e || accept) begin
          buf_clear  = 1'b1;
          issue      = 1'b1;
          state_next = S_WAIT;
        end
      end
      S_DISCARD: begin
        if (imem_rvalid) begin
          issue      = 1'b1;
          state_next = S_WAIT;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // IDLE issues unconditionally, so the pulse is masked while reset is held.
  assign imem_req  = issue & rst_n;
  assign imem_addr = pc_next;

  // IF/ID: a flush or redirect bubbles even through stall_d.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_d    <= NOP_INSTR;
      pc_d       <= '0;
      pc_plus4_d <= '0;
      valid_d    <= 1'b0;
      fetch_wait <= 1'b0;
    end else if (flush_d || pc_src_e) begin
      instr_d    <= NOP_INSTR;
      valid_d    <= 1'b0;
      fetch_wait <= 1'b0;
    end else if (!stall_d) begin
      if (accept) begin
        instr_d    <= word_f;
        pc_d       <= word_pc;
        pc_plus4_d <= word_pc + XLEN'(4);
        valid_d    <= 1'b1;
        fetch_wait <= 1'b0;
      end else begin
        instr_d    <= NOP_INSTR;
        valid_d    <= 1'b0;
        fetch_wait <= 1'b1;
      end
    end
  end

  // A response with nothing live outstanding is a memory protocol error.
  a_no_stray_rvalid: assert property (@(posedge clk) disable iff (!rst_n)
    !(imem_rvalid && ((state == S_IDLE) || (state == S_FULL))));

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Self-checking bench for fetch_stage: vector table, directed
//               redirect/reset sequences and a randomized run against a
//               transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_f, stall_d, flush_d, pc_src_e;
  logic [31:0] pc_target_e;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr_d, pc_d, pc_plus4_d;
  logic        valid_d, fetch_wait;

  fetch_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall_f     (stall_f),
    .stall_d     (stall_d),
    .flush_d     (flush_d),
    .pc_src_e    (pc_src_e),
    .pc_target_e (pc_target_e),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_d     (instr_d),
    .pc_d        (pc_d),
    .pc_plus4_d  (pc_plus4_d),
    .valid_d     (valid_d),
    .fetch_wait  (fetch_wait)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // memory model state
  int          mem_lat;
  bit          mem_rand_lat;
  bit          mem_pend;
  int          mem_cnt;
  logic [31:0] mem_addr;
  logic [31:0] mem_xor;

  // reference model state
  logic [31:0] m_pc;
  bit          m_out, m_stale, m_bvalid;
  logic [31:0] m_bword;
  logic [31:0] e_instr, e_pc, e_pc4;
  bit          e_vld, e_fw;

  typedef struct {
    int          new_run;
    int          lat;
    int          sf;
    int          sd;
    int          e_req;
    logic [31:0] e_addr;
    int          e_vld;
    logic [31:0] e_pc;
    int          e_fw;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add_vec(input int nr, input int lat, input int sf, input int sd,
                         input int rq, input logic [31:0] ad, input int vl,
                         input logic [31:0] pc, input int fw);
    vec_t v;
    v.new_run = nr; v.lat = lat; v.sf = sf; v.sd = sd; v.e_req = rq;
    v.e_addr = ad; v.e_vld = vl; v.e_pc = pc; v.e_fw = fw;
    vecs.push_back(v);
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  // Finish the current cycle: latch any request into the memory model, then
  // present the response (if due) for the following cycle.
  task automatic advance();
    bit          req_seen;
    logic [31:0] addr_seen;
    req_seen  = imem_req;
    addr_seen = imem_addr;
    if (req_seen) chk("one_outstanding", {31'b0, mem_pend}, 32'd0);
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    if (req_seen) begin
      mem_pend = 1'b1;
      mem_cnt  = mem_rand_lat ? int'($urandom_range(1, 3)) : mem_lat;
      mem_addr = addr_seen;
    end
    if (mem_pend) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_addr ^ mem_xor;
        mem_pend    = 1'b0;
      end
    end
  endtask

  task automatic clear_inputs();
    stall_f = 0; stall_d = 0; flush_d = 0; pc_src_e = 0; pc_target_e = '0;
  endtask

  task automatic do_reset(input int lat);
    rst_n = 1'b0;
    clear_inputs();
    mem_lat = lat; mem_pend = 0; imem_rvalid = 0; imem_rdata = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic check_ifid_reset(input string tag);
    chk({tag, "_req"},   {31'b0, imem_req},   32'd0);
    chk({tag, "_instr"}, instr_d,             NOP);
    chk({tag, "_pc"},    pc_d,                32'd0);
    chk({tag, "_pc4"},   pc_plus4_d,          32'd0);
    chk({tag, "_valid"}, {31'b0, valid_d},    32'd0);
    chk({tag, "_fw"},    {31'b0, fetch_wait}, 32'd0);
  endtask

  // Advance until a request for addr is on the bus (left un-advanced).
  task automatic wait_req(input logic [31:0] addr, input int budget);
    bit found = 0;
    for (int i = 0; i < budget && !found; i++) begin
      settle();
      if (imem_req && imem_addr == addr) found = 1;
      else advance();
    end
    chk("wait_req_found", {31'b0, found}, 32'd1);
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_out = 0; m_stale = 0; m_bvalid = 0; m_bword = '0;
    e_instr = NOP; e_pc = '0; e_pc4 = '0; e_vld = 0; e_fw = 0;
  endtask

  // Transaction view: a request goes out whenever nothing is in flight and
  // nothing is parked; the word in hand belongs to the current pc.
  task automatic model_step();
    bit          fresh, have, acc, out_after, stale_after, bv_after, ereq;
    logic [31:0] word, npc;
    chk("rnd_instr", instr_d, e_instr);
    chk("rnd_valid", {31'b0, valid_d}, {31'b0, e_vld});
    chk("rnd_fw",    {31'b0, fetch_wait}, {31'b0, e_fw});
    if (e_vld) begin
      chk("rnd_pc",  pc_d, e_pc);
      chk("rnd_pc4", pc_plus4_d, e_pc4);
    end
    fresh = m_out && !m_stale && imem_rvalid;
    have  = m_bvalid || fresh;
    word  = m_bvalid ? m_bword : imem_rdata;
    acc   = have && !stall_f && !stall_d && !flush_d && !pc_src_e;
    npc   = pc_src_e ? pc_target_e : (acc ? m_pc + 32'd4 : m_pc);
    out_after   = m_out && !imem_rvalid;
    stale_after = out_after && (m_stale || pc_src_e);
    if (pc_src_e || acc) bv_after = 0;
    else if (fresh) begin bv_after = 1; m_bword = imem_rdata; end
    else bv_after = m_bvalid;
    ereq = !out_after && !bv_after;
    chk("rnd_req", {31'b0, imem_req}, {31'b0, ereq});
    if (ereq) begin
      chk("rnd_addr", imem_addr, npc);
      out_after = 1; stale_after = 0;
    end
    if (flush_d || pc_src_e) begin
      e_instr = NOP; e_vld = 0; e_fw = 0;
    end else if (!stall_d) begin
      if (acc) begin
        e_instr = word; e_pc = m_pc; e_pc4 = m_pc + 32'd4; e_vld = 1; e_fw = 0;
      end else begin
        e_instr = NOP; e_vld = 0; e_fw = 1;
      end
    end
    m_pc = npc; m_out = out_after; m_stale = stale_after; m_bvalid = bv_after;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mem_rand_lat = 0; mem_xor = '0; mem_lat = 1;
    rst_n = 1'b0; clear_inputs(); mem_pend = 0; imem_rvalid = 0; imem_rdata = '0;

    // Reset state while reset is held
    settle();
    check_ifid_reset("reset");

    // Vector table: latency 1 streaming, latency 3 bubbles, stall with parked word
    add_vec(1,1,0,0, 1,32'h00, 0,32'h0, 0);
    add_vec(0,1,0,0, 1,32'h04, 0,32'h0, 1);
    add_vec(0,1,0,0, 1,32'h08, 1,32'h0, 0);
    add_vec(0,1,0,0, 1,32'h0C, 1,32'h4, 0);
    add_vec(0,1,0,0, 1,32'h10, 1,32'h8, 0);
    add_vec(1,3,0,0, 1,32'h00, 0,32'h0, 0);
    add_vec(0,3,0,0, 0,32'h00, 0,32'h0, 1);
    add_vec(0,3,0,0, 0,32'h00, 0,32'h0, 1);
    add_vec(0,3,0,0, 1,32'h04, 0,32'h0, 1);
    add_vec(0,3,0,0, 0,32'h00, 1,32'h0, 0);
    add_vec(0,3,0,0, 0,32'h00, 0,32'h0, 1);
    add_vec(0,3,0,0, 1,32'h08, 0,32'h0, 1);
    add_vec(0,3,0,0, 0,32'h00, 1,32'h4, 0);
    add_vec(1,1,0,0, 1,32'h00, 0,32'h0, 0);
    add_vec(0,1,0,0, 1,32'h04, 0,32'h0, 1);
    add_vec(0,1,0,0, 1,32'h08, 1,32'h0, 0);
    add_vec(0,1,1,1, 0,32'h00, 1,32'h4, 0);
    add_vec(0,1,1,1, 0,32'h00, 1,32'h4, 0);
    add_vec(0,1,0,0, 1,32'h0C, 1,32'h4, 0);
    add_vec(0,1,0,0, 1,32'h10, 1,32'h8, 0);
    add_vec(0,1,0,0, 1,32'h14, 1,32'hC, 0);

    foreach (vecs[i]) begin
      if (vecs[i].new_run != 0) do_reset(vecs[i].lat);
      stall_f = (vecs[i].sf != 0);
      stall_d = (vecs[i].sd != 0);
      settle();
      chk($sformatf("vec%0d_req", i), {31'b0, imem_req}, vecs[i].e_req);
      if (vecs[i].e_req != 0) chk($sformatf("vec%0d_addr", i), imem_addr, vecs[i].e_addr);
      chk($sformatf("vec%0d_valid", i), {31'b0, valid_d}, vecs[i].e_vld);
      chk($sformatf("vec%0d_fw", i), {31'b0, fetch_wait}, vecs[i].e_fw);
      if (vecs[i].e_vld != 0) begin
        chk($sformatf("vec%0d_pc", i), pc_d, vecs[i].e_pc);
        chk($sformatf("vec%0d_instr", i), instr_d, vecs[i].e_pc);
      end else begin
        chk($sformatf("vec%0d_instr", i), instr_d, NOP);
      end
      advance();
    end

    // Redirect while the request for 0x10 is outstanding (latency 2)
    do_reset(2);
    wait_req(32'h10, 40);
    advance();
    pc_src_e = 1; pc_target_e = 32'h100;
    settle();
    chk("t4_no_issue", {31'b0, imem_req}, 32'd0);
    advance();
    pc_src_e = 0;
    settle();
    chk("t4_req", {31'b0, imem_req}, 32'd1);
    chk("t4_addr", imem_addr, 32'h100);
    chk("t4_bubble0", {31'b0, valid_d}, 32'd0);
    advance();
    settle();
    chk("t4_idle_wait", {31'b0, imem_req}, 32'd0);
    chk("t4_bubble1", {31'b0, valid_d}, 32'd0);
    advance();
    settle();
    chk("t4_next_req", imem_addr, 32'h104);
    chk("t4_bubble2", {31'b0, valid_d}, 32'd0);
    advance();
    settle();
    chk("t4_valid", {31'b0, valid_d}, 32'd1);
    chk("t4_pc", pc_d, 32'h100);
    chk("t4_pc4", pc_plus4_d, 32'h104);
    chk("t4_instr", instr_d, 32'h100);
    advance();

    // Redirect coincident with a response while decode is stalled
    do_reset(2);
    settle(); chk("t5_first", imem_addr, 32'h0); advance();
    settle(); advance();
    pc_src_e = 1; pc_target_e = 32'h100; stall_d = 1;
    settle();
    chk("t5_req", {31'b0, imem_req}, 32'd1);
    chk("t5_addr", imem_addr, 32'h100);
    advance();
    pc_src_e = 0; stall_d = 0;
    settle();
    chk("t5_bubble_valid", {31'b0, valid_d}, 32'd0);
    chk("t5_bubble_instr", instr_d, NOP);
    chk("t5_bubble_fw", {31'b0, fetch_wait}, 32'd0);
    advance();
    settle();
    chk("t5_next_addr", imem_addr, 32'h104);
    advance();
    settle();
    chk("t5_valid", {31'b0, valid_d}, 32'd1);
    chk("t5_pc", pc_d, 32'h100);
    advance();

    // Asynchronous reset while a word is parked
    do_reset(1);
    repeat (3) begin settle(); advance(); end
    stall_f = 1; stall_d = 1;
    settle(); advance();
    #2;
    chk("t6_pre_valid", {31'b0, valid_d}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_ifid_reset("t6");
    clear_inputs(); mem_pend = 0; imem_rvalid = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    settle();
    chk("t6_first_req", {31'b0, imem_req}, 32'd1);
    chk("t6_first_addr", imem_addr, 32'h0);
    advance();

    // Randomized run against the reference model
    do_reset(1);
    mem_rand_lat = 1; mem_xor = 32'hC0DE_5A00;
    model_reset();
    for (int c = 0; c < 1000; c++) begin
      stall_d  = ($urandom_range(0, 7) == 0);
      stall_f  = stall_d ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 11) == 0);
      flush_d  = ($urandom_range(0, 13) == 0);
      pc_src_e = ($urandom_range(0, 9) == 0);
      pc_target_e = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
      settle();
      model_step();
      advance();
    end
    clear_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
